// File: rtl/ssegment_scan.sv
// ssegment_scan: converts an unsigned binary value to BCD with a serial double-dabble
// engine and drives a multiplexed, active-low seven-segment display.
// Optional feature: define LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 is
// never blanked, and the overflow dash pattern is unaffected).

module ssegment_scan #(
  parameter int unsigned DATA_W   = 6,
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              ovf
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] SegZero  = 7'b0000001;
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b1111110;

  typedef enum logic {
    StIdle,
    StConv
  } state_e;

  // Conversion engine state
  state_e            r_state;
  state_e            w_state_next;
  logic [DATA_W-1:0] r_bin;
  logic [BcdW-1:0]   r_bcd;
  logic [CntW-1:0]   r_cnt;
  logic              r_ovf_acc;

  // Display and scan state
  logic [BcdW-1:0]   r_disp;
  logic              r_ovf;
  logic [PreW-1:0]   r_pre;
  logic [IdxW-1:0]   r_idx;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_an;

  // Combinational helpers
  logic [BcdW-1:0]   w_adj;
  logic [BcdW-1:0]   w_bcd_step;
  logic              w_carry;
  logic [DATA_W-1:0] w_bin_step;
  logic              w_last;
  logic              w_done;
  logic [BcdW-1:0]   w_disp_next;
  logic              w_ovf_next;
  logic              w_pre_tc;
  logic [PreW-1:0]   w_pre_next;
  logic [IdxW-1:0]   w_idx_next;
  logic [3:0]        w_digit;
  logic              w_sel_blank;
  logic [6:0]        w_seg_next;
  logic [DIGITS-1:0] w_an_next;

  // Seven-segment code for one BCD digit; non-decimal nibbles cannot occur and show blank.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b0000001;
      4'd1:    c = 7'b1001111;
      4'd2:    c = 7'b0010010;
      4'd3:    c = 7'b0000110;
      4'd4:    c = 7'b1001100;
      4'd5:    c = 7'b0100100;
      4'd6:    c = 7'b0100000;
      4'd7:    c = 7'b0001111;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0000100;
      default: c = 7'b1111111;
    endcase
    return c;
  endfunction

  // One double-dabble step: add 3 to each nibble >= 5, then shift in the next binary MSB.
  // The bit shifted out of the top nibble is a carry into a digit we do not hold.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
    w_bcd_step = {w_adj[BcdW-2:0], r_bin[DATA_W-1]};
    w_carry    = w_adj[BcdW-1];
    w_bin_step = r_bin << 1;
  end

  // FSM next state: IDLE waits for load, CONV runs exactly DATA_W steps.
  always_comb begin
    w_state_next = r_state;
    w_last       = (r_cnt == CntW'(DATA_W - 1));
    w_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (load) begin
          w_state_next = StConv;
        end
      end
      StConv: begin
        if (w_last) begin
          w_state_next = StIdle;
          w_done       = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Display and overflow take the final step result on the same edge that leaves CONV.
  always_comb begin
    w_disp_next = r_disp;
    w_ovf_next  = r_ovf;
    if (w_done) begin
      w_disp_next = w_bcd_step;
      w_ovf_next  = r_ovf_acc | w_carry;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Conversion datapath; load is only honoured in IDLE so an in-flight conversion is safe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
    end else if (r_state == StIdle) begin
      if (load) begin
        r_bin     <= data_in;
        r_bcd     <= '0;
        r_cnt     <= '0;
        r_ovf_acc <= 1'b0;
      end
    end else begin
      r_bin     <= w_bin_step;
      r_bcd     <= w_bcd_step;
      r_cnt     <= r_cnt + CntW'(1);
      r_ovf_acc <= r_ovf_acc | w_carry;
    end
  end

  // Display register and overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_disp <= w_disp_next;
      r_ovf  <= w_ovf_next;
    end
  end

  // Prescaler and digit index; with DIGITS=1 the wrap compare keeps the index at 0.
  always_comb begin
    w_pre_tc   = (r_pre == PreW'(SCAN_DIV - 1));
    w_pre_next = w_pre_tc ? '0 : r_pre + PreW'(1);
    w_idx_next = r_idx;
    if (w_pre_tc) begin
      w_idx_next = (r_idx == IdxW'(DIGITS - 1)) ? '0 : r_idx + IdxW'(1);
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic [DIGITS-1:0] w_blank;

  // A digit is blank when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    logic v_higher_zero;
    w_blank       = '0;
    v_higher_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      v_higher_zero = v_higher_zero & (w_disp_next[4*i +: 4] == 4'd0);
      if (i != 0) begin
        w_blank[i] = v_higher_zero;
      end
    end
  end
`endif

  // Select the digit for the upcoming scan slot so seg/an track index and display exactly.
  always_comb begin
    w_digit     = 4'd0;
    w_sel_blank = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (IdxW'(i) == w_idx_next) begin
        w_digit = w_disp_next[4*i +: 4];
`ifdef LEAD_ZERO_BLANK_EN
        w_sel_blank = w_blank[i];
`endif
      end
    end
    if (w_ovf_next) begin
      w_seg_next = SegDash;
    end else if (w_sel_blank) begin
      w_seg_next = SegBlank;
    end else begin
      w_seg_next = seg_code(w_digit);
    end
    w_an_next = ~(DIGITS'(1) << w_idx_next);
  end

  // Scan counters and registered display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= '0;
      r_seg <= SegZero;
      r_an  <= ~DIGITS'(1);
    end else begin
      r_pre <= w_pre_next;
      r_idx <= w_idx_next;
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  assign seg  = r_seg;
  assign an   = r_an;
  assign busy = (r_state == StConv);
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_ssegment_scan.sv
// Scoreboard bench for ssegment_scan: stimulus pushes expected displays into a queue, a
// monitor pops one on every end-of-conversion and checks busy length, ovf and both digits.
// A second DIGITS=1 instance covers overflow and the fixed digit enable.

module tb_ssegment_scan;

  localparam int DW = 6;
  localparam int DG = 2;
  localparam int SD = 4;

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b0000001;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          load = 1'b0;
  logic [6:0]    seg;
  logic [DG-1:0] an;
  logic          busy;
  logic          ovf;

  logic [DW-1:0] data1 = '0;
  logic          load1 = 1'b0;
  logic [6:0]    seg1;
  logic [0:0]    an1;
  logic          busy1;
  logic          ovf1;

  int errors = 0;
  int checks = 0;
  logic mon_busy = 1'b0;

  typedef struct {
    logic       ovf;
    logic [6:0] s0;
    logic [6:0] s1;
    int         val;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  ssegment_scan #(.DATA_W(DW), .DIGITS(DG), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load),
    .seg(seg), .an(an), .busy(busy), .ovf(ovf)
  );

  ssegment_scan #(.DATA_W(DW), .DIGITS(1), .SCAN_DIV(3)) dut1 (
    .clk(clk), .reset(reset), .data_in(data1), .load(load1),
    .seg(seg1), .an(an1), .busy(busy1), .ovf(ovf1)
  );

  // Digit code table written out independently of the design.
  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t mk(input logic o, input logic [6:0] s0, input logic [6:0] s1,
                              input int v);
    exp_t e;
    e.ovf = o;
    e.s0  = s0;
    e.s1  = s1;
    e.val = v;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Watch the scan until both digits have been seen (bounded), sampling on negedges.
  task automatic scan_digits(output logic [6:0] g0, output logic [6:0] g1);
    logic f0, f1;
    g0 = 7'bx;
    g1 = 7'bx;
    f0 = 1'b0;
    f1 = 1'b0;
    for (int c = 0; c < 4 * SD * DG && !(f0 && f1); c++) begin
      if (an == 2'b10) begin
        g0 = seg;
        f0 = 1'b1;
      end else if (an == 2'b01) begin
        g1 = seg;
        f1 = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_load(input int v, input exp_t e);
    @(posedge clk);
    #1;
    data_in = DW'(v);
    load    = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: actual=timeout after %0d cycles required=update", n);
      exp_q.delete();
    end
  endtask

  // Cycles the scan index stays on one digit, and the enable pattern it moves to.
  task automatic slot_len(output int n, output logic [DG-1:0] after);
    logic [DG-1:0] start;
    start = an;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (an == start && n < 100);
    after = an;
  endtask

  task automatic run1(input int v, input logic eo, input logic [6:0] es);
    int n;
    @(posedge clk);
    #1;
    data1 = DW'(v);
    load1 = 1'b1;
    @(posedge clk);
    #1;
    load1 = 1'b0;
    n = 0;
    while (busy1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("d1_busy_len_%0d", v), n, DW);
    chk($sformatf("d1_ovf_%0d", v), ovf1, eo);
    chk($sformatf("d1_seg_%0d", v), seg1, es);
    chk($sformatf("d1_an_%0d", v), an1, 0);
  endtask

  // Monitor: a busy 1->0 transition outside reset is one completed conversion.
  initial begin : monitor
    logic       prev_busy;
    int         bcnt;
    exp_t       e;
    logic [6:0] g0, g1;
    prev_busy = 1'b0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        bcnt = 0;
      end else if (busy) begin
        prev_busy = 1'b1;
        bcnt++;
      end else if (prev_busy) begin
        prev_busy = 1'b0;
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: actual=update required=none");
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("busy_len_%0d", e.val), bcnt, DW);
          chk($sformatf("ovf_%0d", e.val), ovf, e.ovf);
          chk($sformatf("an_onehot_%0d", e.val), an, (an == 2'b01) ? 2'b01 : 2'b10);
          chk($sformatf("seg_at_update_%0d", e.val), seg, (an == 2'b10) ? e.s0 : e.s1);
          scan_digits(g0, g1);
          chk($sformatf("digit0_%0d", e.val), g0, e.s0);
          chk($sformatf("digit1_%0d", e.val), g1, e.s1);
        end
        bcnt = 0;
        mon_busy = 1'b0;
      end
    end
  end

  // Directed stimulus
  initial begin : stim
    int            n;
    logic [DG-1:0] a;
    logic [6:0]    g0, g1;

    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_an", an, 2'b10);
    chk("rst_seg", seg, 7'b0000001);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_an1", an1, 0);
    chk("rst_seg1", seg1, 7'b0000001);
    @(posedge clk);
    #1 reset = 1'b0;

    // Index advances every SD cycles and wraps after DG slots.
    slot_len(n, a);
    chk("slot0_len", n, SD);
    chk("slot0_next_an", a, 2'b01);
    slot_len(n, a);
    chk("slot1_len", n, SD);
    chk("wrap_an", a, 2'b10);
    chk("an1_fixed", an1, 0);

    do_load(37, mk(1'b0, code(7), code(3), 37));
    wait_idle();
    do_load(63, mk(1'b0, code(3), code(6), 63));
    wait_idle();
    do_load(5, mk(1'b0, code(5), LZ, 5));
    wait_idle();

    // Load 12, then a load of 40 two cycles later that must be ignored.
    do_load(12, mk(1'b0, code(2), code(1), 12));
    @(posedge clk);
    #1;
    data_in = DW'(40);
    load    = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    wait_idle();

    // Reset in the middle of converting 25 aborts it and clears the display.
    @(posedge clk);
    #1;
    data_in = DW'(25);
    load    = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("abort_busy", busy, 0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_ovf", ovf, 0);
    @(negedge clk);
    scan_digits(g0, g1);
    chk("abort_digit0", g0, code(0));
    chk("abort_digit1", g1, LZ);
    do_load(25, mk(1'b0, code(5), code(2), 25));
    wait_idle();

    do_load(0, mk(1'b0, code(0), LZ, 0));
    wait_idle();
    do_load(10, mk(1'b0, code(0), code(1), 10));
    wait_idle();

    // Single-digit instance: overflow shows dash, recovery, and an fixed at 0.
    run1(63, 1'b1, 7'b1111110);
    run1(5, 1'b0, code(5));
    run1(10, 1'b1, 7'b1111110);
    run1(9, 1'b0, code(9));

    repeat (4) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=time limit reached required=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
